// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter sharing one SD block engine between the FAT walker (0) and the data streamer (1).
// Latency: grant and eng_start one cycle after a request is seen in IDLE; strobes, done and err are same-cycle.
// Backpressure: a grant is held for one whole block; no new grant while the engine reports busy.
module sd_block_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BYTES = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata0,
    input  logic [7:0]        wdata1,
    output logic [1:0]        gnt,
    output logic [7:0]        rdata,
    output logic [1:0]        byte_strb,
    output logic [1:0]        done,
    output logic              err,
    output logic              eng_start,
    output logic              eng_op,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [7:0]        eng_wdata,
    input  logic [7:0]        eng_rdata,
    input  logic              eng_byte_done,
    input  logic              eng_block_done,
    input  logic              eng_busy
);
    localparam int CNT_W = $clog2(BLOCK_BYTES) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BLOCK_BYTES + 1);

    typedef enum logic [1:0] {IDLE, START, XFER, RELEASE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       gnt_q;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [7:0]       rdata_q;
    logic             active;
    logic             strobe;
    logic             block_end;
    logic             count_ok;
    logic             grant_go;
    logic             pick;

    assign active    = (state == START) || (state == XFER);
    assign strobe    = active && eng_byte_done;
    assign block_end = active && eng_block_done;
    // A byte landing in the same cycle as block_done still counts toward the block.
    assign cnt_nxt   = (eng_byte_done && (cnt != CNT_SAT)) ? cnt + 1'b1 : cnt;
    assign count_ok  = (cnt_nxt == CNT_FULL);

    always_comb begin
        state_nxt = state;
        grant_go  = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
        case (state)
            IDLE: begin
                if ((req != 2'b00) && !eng_busy) begin
                    grant_go  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (block_end)     state_nxt = RELEASE;
                else if (eng_busy) state_nxt = XFER;
            end
            XFER: begin
                if (block_end) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!eng_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_q     <= 2'b00;
            last      <= 1'b1;
            cnt       <= '0;
            rdata_q   <= 8'h00;
            eng_start <= 1'b0;
            eng_op    <= 1'b0;
            eng_addr  <= '0;
        end else begin
            state     <= state_nxt;
            eng_start <= grant_go;
            if (grant_go) begin
                gnt_q    <= pick ? 2'b10 : 2'b01;
                eng_op   <= op[pick];
                eng_addr <= pick ? addr1 : addr0;
                cnt      <= '0;
            end
            if (active) begin
                cnt <= cnt_nxt;
            end
            if (strobe) begin
                rdata_q <= eng_rdata;
            end
            if (block_end) begin
                gnt_q <= 2'b00;
                last  <= gnt_q[1];
                cnt   <= '0;
            end
        end
    end

    assign gnt       = gnt_q;
    assign byte_strb = strobe ? gnt_q : 2'b00;
    assign rdata     = strobe ? eng_rdata : rdata_q;
    assign done      = (block_end && count_ok) ? gnt_q : 2'b00;
    assign err       = block_end && !count_ok;
    assign eng_wdata = gnt_q[0] ? wdata0 : (gnt_q[1] ? wdata1 : 8'h00);

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter with a transaction-level reference model checked every cycle.
module tb_sd_block_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req = 2'b00;
    logic [1:0]  op = 2'b00;
    logic [31:0] addr0 = 32'h0;
    logic [31:0] addr1 = 32'h0;
    logic [7:0]  wdata0 = 8'h00;
    logic [7:0]  wdata1 = 8'h00;
    logic [1:0]  gnt;
    logic [7:0]  rdata;
    logic [1:0]  byte_strb;
    logic [1:0]  done;
    logic        err;
    logic        eng_start;
    logic        eng_op;
    logic [31:0] eng_addr;
    logic [7:0]  eng_wdata;
    logic [7:0]  eng_rdata = 8'h00;
    logic        eng_byte_done = 1'b0;
    logic        eng_block_done = 1'b0;
    logic        eng_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    sd_block_arbiter #(.ADDR_W(32), .BLOCK_BYTES(512)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .rdata(rdata), .byte_strb(byte_strb),
        .done(done), .err(err), .eng_start(eng_start), .eng_op(eng_op), .eng_addr(eng_addr),
        .eng_wdata(eng_wdata), .eng_rdata(eng_rdata), .eng_byte_done(eng_byte_done),
        .eng_block_done(eng_block_done), .eng_busy(eng_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the engine, bytes seen, whose turn is next.
    int          m_owner = -1;
    bit          m_rel = 1'b0;
    int          m_last = 1;
    int          m_cnt = 0;
    bit          m_start = 1'b0;
    logic [7:0]  m_hold = 8'h00;
    bit          m_op = 1'b0;
    logic [31:0] m_addr = 32'h0;
    int n_strb0 = 0, n_strb1 = 0, n_done0 = 0, n_done1 = 0, n_err = 0, n_start = 0;

    always @(negedge clk) begin
        logic [1:0] e_gnt, e_strb, e_done;
        logic [7:0] e_rdata, e_wdata;
        bit         strobe, fin, e_err;
        int         pick;
        if (!rst_n) begin
            chk("rst_gnt", 64'(gnt), 64'(0));
            chk("rst_strb", 64'(byte_strb), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_err", 64'(err), 64'(0));
            chk("rst_start", 64'(eng_start), 64'(0));
            chk("rst_rdata", 64'(rdata), 64'(0));
            chk("rst_wdata", 64'(eng_wdata), 64'(0));
            m_owner = -1; m_rel = 0; m_last = 1; m_cnt = 0; m_start = 0; m_hold = 8'h00;
        end else begin
            e_gnt   = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
            strobe  = (m_owner >= 0) && eng_byte_done;
            fin     = (m_owner >= 0) && eng_block_done;
            e_strb  = strobe ? e_gnt : 2'b00;
            e_rdata = strobe ? eng_rdata : m_hold;
            e_err   = fin && ((m_cnt + int'(eng_byte_done)) != 512);
            e_done  = (fin && !e_err) ? e_gnt : 2'b00;
            e_wdata = (m_owner == 0) ? wdata0 : ((m_owner == 1) ? wdata1 : 8'h00);
            chk("gnt", 64'(gnt), 64'(e_gnt));
            chk("byte_strb", 64'(byte_strb), 64'(e_strb));
            chk("rdata", 64'(rdata), 64'(e_rdata));
            chk("done", 64'(done), 64'(e_done));
            chk("err", 64'(err), 64'(e_err));
            chk("eng_start", 64'(eng_start), 64'(m_start));
            chk("eng_wdata", 64'(eng_wdata), 64'(e_wdata));
            if (m_owner >= 0) begin
                chk("eng_op", 64'(eng_op), 64'(m_op));
                chk("eng_addr", 64'(eng_addr), 64'(m_addr));
            end
            n_strb0 += int'(byte_strb[0]); n_strb1 += int'(byte_strb[1]);
            n_done0 += int'(done[0]); n_done1 += int'(done[1]);
            n_err += int'(err); n_start += int'(eng_start);
            if (strobe) m_hold = eng_rdata;
            m_start = 0;
            if (m_owner >= 0) begin
                m_cnt += int'(eng_byte_done);
                if (fin) begin m_last = m_owner; m_owner = -1; m_rel = 1; end
            end else if (m_rel) begin
                if (!eng_busy) m_rel = 0;
            end else if (req != 2'b00 && !eng_busy) begin
                pick = (req == 2'b01) ? 0 : ((req == 2'b10) ? 1 : (m_last == 0 ? 1 : 0));
                m_owner = pick; m_start = 1; m_cnt = 0;
                m_op = op[pick]; m_addr = (pick == 1) ? addr1 : addr0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 2'b00; eng_busy = 0; eng_byte_done = 0; eng_block_done = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Engine model: waits for the command, streams nbytes, ends the block.
    task automatic engine_block(input int nbytes, input bit coincide, input bit keep_req,
                                input bit mid_change, output int who);
        int t = 0;
        who = -1;
        while (eng_start !== 1'b1 && t < 100) begin tick(); t++; end
        if (t >= 100) begin
            chk("start_timeout", 64'(0), 64'(1));
            return;
        end
        who = gnt[1] ? 1 : 0;
        chk("grant_op", 64'(eng_op), 64'(op[who]));
        chk("grant_wdata", 64'(eng_wdata), 64'(who == 1 ? wdata1 : wdata0));
        if (!keep_req) req = 2'b00;
        tick();
        eng_busy = 1;
        tick();
        for (int i = 0; i < nbytes; i++) begin
            eng_byte_done = 1;
            eng_rdata = 8'(i * 37 + 11);
            if (coincide && i == nbytes - 1) eng_block_done = 1;
            if (mid_change && i == 100) begin addr1 = 32'hDEAD_BEEF; op = 2'b00; end
            tick();
        end
        eng_byte_done = 0;
        if (!coincide) begin eng_block_done = 1; tick(); end
        eng_block_done = 0;
        tick();
        eng_busy = 0;
        tick();
    endtask

    initial begin
        int who;
        int whos[4];
        int s_strb0, s_done0, s_done1, s_err, s_start;
        rst_n = 1'b1;
        #2;
        do_reset();
        chk("reset_gnt", 64'(gnt), 64'(0));
        chk("reset_rdata", 64'(rdata), 64'(0));
        chk("reset_eng_addr", 64'(eng_addr), 64'(0));

        // Single client 0 read.
        s_strb0 = n_strb0; s_done0 = n_done0; s_err = n_err; s_start = n_start;
        addr0 = 32'h0000_2000; op = 2'b00; req = 2'b01;
        tick();
        chk("t1_gnt_latency", 64'(gnt), 64'(2'b01));
        chk("t1_start", 64'(eng_start), 64'(1));
        chk("t1_addr", 64'(eng_addr), 64'(32'h2000));
        chk("t1_op", 64'(eng_op), 64'(0));
        engine_block(512, 0, 0, 0, who);
        chk("t1_strb_count", 64'(n_strb0 - s_strb0), 64'(512));
        chk("t1_done_count", 64'(n_done0 - s_done0), 64'(1));
        chk("t1_err_count", 64'(n_err - s_err), 64'(0));
        chk("t1_start_count", 64'(n_start - s_start), 64'(1));

        // Both clients requesting: alternation 0,1,0,1.
        do_reset();
        wdata0 = 8'h5A; wdata1 = 8'hA5; op = 2'b10; addr0 = 32'h1000; addr1 = 32'h3000; req = 2'b11;
        for (int b = 0; b < 4; b++) begin
            engine_block(512, 0, (b < 3), 0, who);
            whos[b] = who;
        end
        chk("t2_order0", 64'(whos[0]), 64'(0));
        chk("t2_order1", 64'(whos[1]), 64'(1));
        chk("t2_order2", 64'(whos[2]), 64'(0));
        chk("t2_order3", 64'(whos[3]), 64'(1));

        // Byte-count checking.
        op = 2'b00;
        s_done0 = n_done0; s_err = n_err;
        req = 2'b01; engine_block(511, 0, 0, 0, who);
        chk("t3_511_err", 64'(n_err - s_err), 64'(1));
        chk("t3_511_done", 64'(n_done0 - s_done0), 64'(0));
        s_done0 = n_done0; s_err = n_err;
        req = 2'b01; engine_block(513, 0, 0, 0, who);
        chk("t3_513_err", 64'(n_err - s_err), 64'(1));
        chk("t3_513_done", 64'(n_done0 - s_done0), 64'(0));
        s_done0 = n_done0; s_err = n_err;
        req = 2'b01; engine_block(512, 1, 0, 0, who);
        chk("t3_coinc_done", 64'(n_done0 - s_done0), 64'(1));
        chk("t3_coinc_err", 64'(n_err - s_err), 64'(0));

        // Client 1 drops req and changes addr1 mid-block.
        s_done1 = n_done1;
        addr1 = 32'h0000_4444; op = 2'b10; req = 2'b10;
        engine_block(512, 0, 0, 1, who);
        chk("t4_who", 64'(who), 64'(1));
        chk("t4_done1", 64'(n_done1 - s_done1), 64'(1));
        chk("t4_addr_kept", 64'(eng_addr), 64'(32'h4444));

        // Asynchronous reset mid-block with the engine still busy.
        addr0 = 32'h0000_7000; op = 2'b00; req = 2'b01;
        tick();
        eng_busy = 1; req = 2'b00;
        tick();
        for (int i = 0; i < 200; i++) begin
            eng_byte_done = 1; eng_rdata = 8'(i); tick();
        end
        rst_n = 1'b0;
        #1;
        chk("t5_async_gnt", 64'(gnt), 64'(0));
        chk("t5_async_strb", 64'(byte_strb), 64'(0));
        chk("t5_async_rdata", 64'(rdata), 64'(0));
        chk("t5_async_addr", 64'(eng_addr), 64'(0));
        tick();
        eng_byte_done = 0; rst_n = 1'b1; req = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_hold_gnt", 64'(gnt), 64'(0));
        end
        eng_busy = 0;
        tick();
        chk("t5_gnt_after_idle", 64'(gnt), 64'(2'b01));
        engine_block(512, 0, 0, 0, who);

        // Busy engine in IDLE blocks the grant.
        eng_busy = 1; req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_busy_gnt", 64'(gnt), 64'(0));
        end
        eng_busy = 0;
        tick();
        chk("t6_gnt_latency", 64'(gnt), 64'(2'b01));
        chk("t6_start", 64'(eng_start), 64'(1));
        engine_block(512, 0, 0, 0, who);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
